// File: rtl/shift7.sv
// Parallel-load, LSB-first serializer: loads datain during reset, then rotates
// right once per clock and shifts sreg[0] out on dataout.
module shift7 #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] datain,
   output logic             dataout
);

   logic [WIDTH-1:0] r_sreg;
   logic             r_run;
   logic             r_dataout;
   logic [WIDTH-1:0] w_sreg;

   // Architectural sreg: transparent to datain until the first shift edge after
   // release, so a change on datain during reset is visible without a clock.
   assign w_sreg = r_run ? r_sreg : datain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run     <= 1'b0;
         r_dataout <= 1'b0;
      end else begin
         r_run     <= 1'b1;
         r_dataout <= w_sreg[0];
      end
   end

   // Edges during reset rotate stale data here, but w_sreg masks it until r_run.
   always_ff @(posedge clk) begin
      r_sreg <= {w_sreg[0], w_sreg[WIDTH-1:1]};
   end

   assign dataout = r_dataout;

endmodule

// File: tb/tb_shift7.sv
// Directed bench for shift7: table of load patterns with hand-computed output
// sequences, plus hand-written reset-timing sequences.
module tb_shift7;

  logic       clk;
  logic       rst;
  logic [6:0] datain;
  logic       dataout;

  int n_cmp;
  int n_bad;

  typedef struct {
    string      name;
    logic [6:0] din;
    logic [13:0] exp;     // bit k-1 = dataout expected at edge k after release
    logic       scramble; // randomize datain while running
  } vec_t;

  vec_t vecs[7];

  shift7 #(.WIDTH(7)) dut (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .dataout (dataout)
  );

  // clock: posedges at 20, 60, 100, ... ns
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dataout=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Assert reset between edges, load din, release just after a posedge,
  // then compare 14 edges against the expected table entry.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    #3 rst = 1'b0;
    #1 check({v.name, "/rst_val"}, dataout, 1'b0);
    datain = v.din;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #5 check($sformatf("%s/edge%0d", v.name, k + 1), dataout, v.exp[k]);
      if (v.scramble) datain = 7'($urandom_range(0, 127));
    end
  endtask

  initial begin
    logic [6:0]  pat;
    logic [13:0] seq;
    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{"zeros",   7'h00,       14'b0000000_0000000, 1'b0};
    vecs[1] = '{"ones",    7'h7F,       14'b1111111_1111111, 1'b0};
    vecs[2] = '{"single1", 7'b1000000,  14'b1000000_1000000, 1'b0};
    vecs[3] = '{"alt55",   7'h55,       14'b1010101_1010101, 1'b0};
    vecs[4] = '{"alt2a",   7'h2A,       14'b0101010_0101010, 1'b0};
    vecs[5] = '{"iso4b",   7'h4B,       14'b1001011_1001011, 1'b1};
    vecs[6] = '{"iso01",   7'h01,       14'b0000001_0000001, 1'b1};

    // Basic serialization with absolute timing
    rst    = 1'b1;
    datain = 7'b1110101;
    #50 rst = 1'b0;
    #1 check("basic/rst_val", dataout, 1'b0);
    #99 rst = 1'b1;
    seq = 14'b1110101_1110101;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #5 check($sformatf("basic/edge%0d", k + 1), dataout, seq[k]);
    end

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Load during reset with no clock edge while held: datain changes 55 -> 0F
    @(negedge clk);
    #2 rst = 1'b0;
    datain = 7'h55;
    #1 check("load/rst_val", dataout, 1'b0);
    #3 datain = 7'h0F;
    #3 rst = 1'b1;
    seq = 14'b0001111_0001111;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #5 check($sformatf("load/edge%0d", k + 1), dataout, seq[k]);
    end

    // Mid-rotation reset: 0F running, abort while dataout=1, reload 13
    @(negedge clk);
    #2 rst = 1'b0;
    datain = 7'h0F;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #5 check($sformatf("abort/pre%0d", k + 1), dataout, 1'b1);
    end
    #5 rst = 1'b0;
    #1 check("abort/rst_imm", dataout, 1'b0);
    datain = 7'h13;
    @(posedge clk);
    #5 check("abort/edge_in_rst", dataout, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    pat = 7'h13;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #5 check($sformatf("abort/edge%0d", k + 1), dataout, pat[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
